// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer blocks (write and read side).
package fifo_pkg;

    localparam int ADDR_SIZE = 6;
    localparam int PTR_W     = ADDR_SIZE + 1;

    // Binary to reflected Gray code; callers keep the low bits they need.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Gray to binary via XOR prefix from the MSB down; zero upper bits are harmless.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i + 1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wptr_full_if.sv
// Writer-side signal bundle of the asynchronous FIFO write pointer block.
interface fifo_wptr_full_if #(
    parameter int ADDR_SIZE = fifo_pkg::ADDR_SIZE
);
    logic                 w_en;
    logic                 clr_ovf;
    logic [ADDR_SIZE:0]   sync_rptr;
    logic                 w_inc;
    logic [ADDR_SIZE-1:0] w_addr;
    logic [ADDR_SIZE:0]   w_ptr;
    logic                 full;
    logic                 almost_full;
    logic [ADDR_SIZE:0]   w_count;
    logic                 overflow;

    // Writer / environment side.
    modport master (
        output w_en, clr_ovf, sync_rptr,
        input  w_inc, w_addr, w_ptr, full, almost_full, w_count, overflow
    );

    // Pointer block side.
    modport slave (
        input  w_en, clr_ovf, sync_rptr,
        output w_inc, w_addr, w_ptr, full, almost_full, w_count, overflow
    );
endinterface

// File: rtl/fifo_wptr_full_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at and above it.
module gray2bin #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end
endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full/almost-full/count/overflow generator of the asynchronous FIFO.
// The Gray pointer sent across domains comes straight from a flop, so it never glitches.
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = fifo_pkg::ADDR_SIZE,
    parameter int AF_MARGIN = 2
) (
    input  logic            clk,
    input  logic            rst,
    fifo_wptr_full_if.slave bus
);
    localparam int PW    = ADDR_SIZE + 1;
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] bin_r;
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] count_r;
    logic          full_r;
    logic          af_r;
    logic          ovf_r;

    logic          w_inc_s;
    logic [PW-1:0] bin_next_s;
    logic [PW-1:0] gray_next_s;
    logic [31:0]   gray_wide_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] count_next_s;
    logic [PW-1:0] full_ptr_s;
    logic          full_next_s;
    logic          af_next_s;
    logic          ovf_next_s;

    gray2bin #(.WIDTH(PW)) u_rptr_g2b (
        .gray (bus.sync_rptr),
        .bin  (rbin_s)
    );

    // Next pointer, Gray encoding, fill level and status flags for the coming edge.
    always_comb begin
        w_inc_s      = bus.w_en & ~full_r;
        bin_next_s   = bin_r + {{(PW-1){1'b0}}, w_inc_s};
        gray_wide_s  = bin2gray(32'(bin_next_s));
        gray_next_s  = gray_wide_s[PW-1:0];
        // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
        full_ptr_s   = {~bus.sync_rptr[PW-1:PW-2], bus.sync_rptr[PW-3:0]};
        full_next_s  = (gray_next_s == full_ptr_s);
        count_next_s = bin_next_s - rbin_s;
        af_next_s    = (count_next_s >= AF_LEVEL);
        // A blocked write sets the sticky flag and wins over a same-cycle clear.
        if (bus.w_en && full_r) begin
            ovf_next_s = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // State and status registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r   <= {PW{1'b0}};
            ptr_r   <= {PW{1'b0}};
            count_r <= {PW{1'b0}};
            full_r  <= 1'b0;
            af_r    <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            bin_r   <= bin_next_s;
            ptr_r   <= gray_next_s;
            count_r <= count_next_s;
            full_r  <= full_next_s;
            af_r    <= af_next_s;
            ovf_r   <= ovf_next_s;
        end
    end

    assign bus.w_inc       = w_inc_s;
    assign bus.w_addr      = bin_r[ADDR_SIZE-1:0];
    assign bus.w_ptr       = ptr_r;
    assign bus.full        = full_r;
    assign bus.almost_full = af_r;
    assign bus.w_count     = count_r;
    assign bus.overflow    = ovf_r;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (ADDR_SIZE=2, DEPTH=4, AF_MARGIN=1).
// Reference model tracks total writes and total reads as plain integers.
module tb_fifo_wptr_full;
    localparam int AS    = 2;
    localparam int DEPTH = 4;
    localparam int AFM   = 1;

    logic clk;
    logic rst;

    fifo_wptr_full_if #(.ADDR_SIZE(AS)) bus ();

    fifo_wptr_full #(.ADDR_SIZE(AS), .AF_MARGIN(AFM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors;
    int miscompares;

    // Reference model state
    int m_wr;
    int m_rd;
    int m_full;
    int m_af;
    int m_cnt;
    int m_ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] gray_of(input int n);
        logic [2:0] b;
        b = 3'(n % 8);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_full = 0; m_af = 0; m_cnt = 0; m_ovf = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".w_ptr"},  32'(bus.w_ptr),       32'(gray_of(m_wr)));
        check({tag, ".w_addr"}, 32'(bus.w_addr),      32'(m_wr % DEPTH));
        check({tag, ".count"},  32'(bus.w_count),     32'(m_cnt));
        check({tag, ".full"},   32'(bus.full),        32'(m_full));
        check({tag, ".af"},     32'(bus.almost_full), 32'(m_af));
        check({tag, ".ovf"},    32'(bus.overflow),    32'(m_ovf));
    endtask

    // One clock: drive inputs, check the combinational strobe, clock, update model, check outputs.
    task automatic cycle(input string tag, input bit wen, input bit clr, input int rd_new);
        logic [2:0] prev_ptr;
        int acc;
        prev_ptr = bus.w_ptr;
        bus.w_en      = wen;
        bus.clr_ovf   = clr;
        bus.sync_rptr = gray_of(rd_new);
        #1;
        acc = (wen && (m_full == 0)) ? 1 : 0;
        check({tag, ".w_inc"}, 32'(bus.w_inc), 32'(acc));
        @(posedge clk);
        if (wen && (m_full != 0)) m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_wr   = m_wr + acc;
        m_rd   = rd_new;
        m_cnt  = m_wr - m_rd;
        m_full = (m_cnt == DEPTH) ? 1 : 0;
        m_af   = (m_cnt >= DEPTH - AFM) ? 1 : 0;
        #1;
        check_all(tag);
        check({tag, ".onebit"}, 32'($countones(bus.w_ptr ^ prev_ptr) <= 1), 32'd1);
        check({tag, ".full_cnt"}, 32'(bus.full && (bus.w_count < 3'(DEPTH))), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        bus.w_en = 1'b0;
        bus.clr_ovf = 1'b0;
        bus.sync_rptr = 3'b000;
        model_reset();
        @(posedge clk); #1;
        do_reset();

        // Reset mid-stream with W_PTR = 010, held across edges while writes are requested
        for (int i = 0; i < 3; i++) cycle("pre", 1'b1, 1'b0, 0);
        check("pre.ptr010", 32'(bus.w_ptr), 32'h2);
        #2;
        rst = 1'b1;
        bus.w_en = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all("rst_held");
        rst = 1'b0;
        bus.w_en = 1'b0;
        #1;

        // Fill
        cycle("fill1", 1'b1, 1'b0, 0);
        check("fill1.ptr", 32'(bus.w_ptr), 32'h1);
        cycle("fill2", 1'b1, 1'b0, 0);
        check("fill2.ptr", 32'(bus.w_ptr), 32'h3);
        cycle("fill3", 1'b1, 1'b0, 0);
        check("fill3.ptr", 32'(bus.w_ptr), 32'h2);
        check("fill3.af", 32'(bus.almost_full), 32'd1);
        check("fill3.full", 32'(bus.full), 32'd0);
        cycle("fill4", 1'b1, 1'b0, 0);
        check("fill4.ptr", 32'(bus.w_ptr), 32'h6);
        check("fill4.full", 32'(bus.full), 32'd1);
        check("fill4.count", 32'(bus.w_count), 32'd4);

        // Overflow handling
        cycle("ovf_set", 1'b1, 1'b0, 0);
        check("ovf_set.ptr", 32'(bus.w_ptr), 32'h6);
        check("ovf_set.ovf", 32'(bus.overflow), 32'd1);
        cycle("ovf_clr", 1'b0, 1'b1, 0);
        check("ovf_clr.ovf", 32'(bus.overflow), 32'd0);
        cycle("ovf_both", 1'b1, 1'b1, 0);
        check("ovf_both.ovf", 32'(bus.overflow), 32'd1);
        cycle("ovf_clr2", 1'b0, 1'b1, 0);

        // Drain release and refill
        cycle("drain", 1'b0, 1'b0, 1);
        check("drain.full", 32'(bus.full), 32'd0);
        check("drain.count", 32'(bus.w_count), 32'd3);
        cycle("refill", 1'b1, 1'b0, 1);
        check("refill.full", 32'(bus.full), 32'd1);

        // Wrap with read pointer trailing by two
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle("wrap", 1'b1, 1'b0, (m_wr >= 2) ? m_wr - 2 : 0);
            check("wrap.msb", 32'(bus.w_ptr[2]), 32'((m_wr / DEPTH) % 2));
        end
        check("wrap.total", 32'(m_wr), 32'd12);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            int rd_next;
            rd_next = m_rd;
            if ((m_rd < m_wr) && ($urandom_range(0, 2) != 0)) rd_next = m_rd + 1;
            cycle("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), rd_next);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
